battle_board_engine: RTL

Parametrised game-state engine for the battleship design. Holds NUM_PLAYERS boards of BOARD_SIZE x BOARD_SIZE 2-bit cells, accepts row-wise board loads during setup, and resolves shots through a valid/ready handshake. Tracks the turn, per-player remaining ship cells and the winner. Exposes registered row views of the current player's own board and the opponent's masked board for VGA_CONTROLLER. It replaces the fixed 10x10, two-player row registers and Enter-key turn toggle.

---
 rtl/battle_board_engine.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/battle_board_engine.sv
// Battleship game-state engine: per-player boards, setup row loads and a fire/result handshake.
// Optional build macro BONUS_SHOT_EN: a non-final hit keeps the shooter's turn.
module battle_board_engine #(
  parameter int BOARD_SIZE  = 10,
  parameter int NUM_PLAYERS = 2,
  parameter int SHIP_CELLS  = 17,
  localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int RW = $clog2(BOARD_SIZE),
  localparam int HW = $clog2(SHIP_CELLS + 1),
  localparam int DW = 2 * BOARD_SIZE
) (
  input  logic          clock50,
  input  logic          reset,
  input  logic          start,
  input  logic          load_valid,
  input  logic [PW-1:0] load_player,
  input  logic [RW-1:0] load_row,
  input  logic [DW-1:0] load_data,
  input  logic          fire_valid,
  output logic          fire_ready,
  input  logic [RW-1:0] fire_row,
  input  logic [RW-1:0] fire_col,
  output logic          result_valid,
  output logic [1:0]    result_code,
  output logic [PW-1:0] player_turn,
  output logic [PW-1:0] target_player,
  output logic [HW-1:0] hits_left,
  output logic          game_over,
  output logic [PW-1:0] winner,
  input  logic [RW-1:0] view_row,
  output logic [DW-1:0] view_own,
  output logic [DW-1:0] view_opp
);

  typedef enum logic [2:0] {SETUP, READY, LOOKUP, COMMIT, OVER} state_t;

  state_t        state;
  logic [DW-1:0] board [NUM_PLAYERS][BOARD_SIZE];
  logic [HW-1:0] hits  [NUM_PLAYERS];
  logic [RW-1:0] shot_row, shot_col;
  logic [PW-1:0] shooter, victim;

  logic          shot_in_range;
  logic [RW-1:0] shot_col_sel;
  logic [DW-1:0] shot_line;
  logic [1:0]    shot_cell, shot_code;
  logic [HW-1:0] remaining;
  logic [DW-1:0] own_line, opp_line, opp_masked;

  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    return (32'(p) == NUM_PLAYERS - 1) ? '0 : p + PW'(1);
  endfunction

  assign fire_ready    = (state == READY);
  assign target_player = next_player(player_turn);
  assign hits_left     = hits[target_player];
  assign remaining     = (hits[victim] == '0) ? '0 : hits[victim] - HW'(1);

  // Shot classification from the latched coordinates; out-of-range shots never touch the array.
  always_comb begin
    shot_in_range = (32'(shot_row) < BOARD_SIZE) && (32'(shot_col) < BOARD_SIZE);
    shot_col_sel  = shot_in_range ? shot_col : '0;
    shot_line     = '0;
    if (shot_in_range) shot_line = board[victim][shot_row];
    shot_cell = shot_line[{shot_col_sel, 1'b0} +: 2];
    if (!shot_in_range)   shot_code = 2'b00;
    else if (shot_cell[1]) shot_code = 2'b01;
    else if (shot_cell[0]) shot_code = 2'b11;
    else                   shot_code = 2'b10;
  end

  always_comb begin
    own_line = '0;
    opp_line = '0;
    if (32'(view_row) < BOARD_SIZE) begin
      own_line = board[player_turn][view_row];
      opp_line = board[target_player][view_row];
    end
  end

  // The opponent view hides unhit ships.
  for (genvar gi = 0; gi < BOARD_SIZE; gi++) begin : g_mask
    assign opp_masked[2*gi +: 2] = (opp_line[2*gi +: 2] == 2'b01) ? 2'b00 : opp_line[2*gi +: 2];
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      state        <= SETUP;
      player_turn  <= '0;
      result_valid <= 1'b0;
      result_code  <= '0;
      game_over    <= 1'b0;
      winner       <= '0;
      view_own     <= '0;
      view_opp     <= '0;
      shot_row     <= '0;
      shot_col     <= '0;
      shooter      <= '0;
      victim       <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        hits[p] <= HW'(SHIP_CELLS);
        for (int r = 0; r < BOARD_SIZE; r++) board[p][r] <= '0;
      end
    end else begin
      view_own     <= own_line;
      view_opp     <= opp_masked;
      result_valid <= 1'b0;
      case (state)
        SETUP: begin
          if (load_valid && (32'(load_row) < BOARD_SIZE) && (32'(load_player) < NUM_PLAYERS))
            board[load_player][load_row] <= load_data;
          if (start) begin
            state       <= READY;
            player_turn <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) hits[p] <= HW'(SHIP_CELLS);
          end
        end
        READY: begin
          if (fire_valid) begin
            shot_row <= fire_row;
            shot_col <= fire_col;
            shooter  <= player_turn;
            victim   <= target_player;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          result_valid <= 1'b1;
          result_code  <= shot_code;
          state        <= COMMIT;
        end
        COMMIT: begin
          state <= READY;
          // Codes 10/11 equal the cell value to be written.
          if (result_code[1]) begin
            board[victim][shot_row][{shot_col, 1'b0} +: 2] <= result_code;
            if (result_code[0]) begin
              hits[victim] <= remaining;
              if (remaining == '0) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= shooter;
              end else begin
`ifdef BONUS_SHOT_EN
                player_turn <= player_turn;
`else
                player_turn <= next_player(player_turn);
`endif
              end
            end else begin
              player_turn <= next_player(player_turn);
            end
          end
        end
        OVER: begin
          if (start) begin
            state     <= SETUP;
            game_over <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++)
              for (int r = 0; r < BOARD_SIZE; r++) board[p][r] <= '0;
          end
        end
        default: state <= SETUP;
      endcase
    end
  end

endmodule
